// File: rtl/opcu.sv
// opcu - outport control unit, one per router output port.
//   Arbitrates between inport packet requests, steers the crossbar for the
//   winner, sends PKT_FLITS flits downstream (one pipe_en cycle each) and
//   tracks downstream packet-slot credits.
// Configuration macro: OPCU_RR_EN
//   defined   -> round-robin arbitration starting at an internal pointer
//   undefined -> fixed priority, lowest index wins
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-low
//   rqs_strobe  [N_IN]  level request per inport
//   crt_in      one-cycle pulse, downstream freed one packet slot
//   arb_ack     [N_IN]  one-hot one-cycle grant
//   xbar_sel    [SEL_W] index of granted inport (held until next grant)
//   xbar_en     crossbar path enable
//   pipe_en     flit valid to downstream inport
//   crt_cnt     [CRT_W] credits available
// All outputs are registered.
module opcu #(
  parameter  int N_IN      = 4,
  parameter  int PKT_FLITS = 4,
  parameter  int BUF_PKTS  = 2,
  localparam int SEL_W     = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CRT_W     = $clog2(BUF_PKTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  rqs_strobe,
  input  logic             crt_in,
  output logic [N_IN-1:0]  arb_ack,
  output logic [SEL_W-1:0] xbar_sel,
  output logic             xbar_en,
  output logic             pipe_en,
  output logic [CRT_W-1:0] crt_cnt
);

  localparam int CNT_W = $clog2(PKT_FLITS);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  ack_q, ack_d;
  logic             xen_q, xen_d;
  logic             pen_q, pen_d;
  logic [CRT_W-1:0] crt_q, crt_d;
  logic             grant;
  logic [SEL_W-1:0] win;

`ifdef OPCU_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  int               idx;
  logic             found;

  // Search upward from the pointer, wrapping modulo N_IN.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_IN; i++) begin
      idx = (int'(ptr_q) + i) % N_IN;
      if (!found && rqs_strobe[idx]) begin
        win   = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = SEL_W'((int'(win) + 1) % N_IN);
  end
`else
  // Fixed priority: scan downward so the lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (rqs_strobe[i]) win = SEL_W'(i);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ack_d   = '0;
    xen_d   = 1'b0;
    pen_d   = 1'b0;
    crt_d   = crt_q;
    grant   = 1'b0;

    unique case (state_q)
      IDLE:  if (|rqs_strobe && crt_q != '0) grant = 1'b1;
      GRANT: begin
        state_d = XFER;
        pen_d   = 1'b1;
        xen_d   = 1'b1;
      end
      XFER: begin
        if (cnt_q == '0) begin
          // Last flit: chain straight into the next grant if possible.
          if (|rqs_strobe && crt_q != '0) grant = 1'b1;
          else                            state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          pen_d = 1'b1;
          xen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter is loaded as GRANT is entered so XFER sees PKT_FLITS-1 first.
    if (grant) begin
      state_d    = GRANT;
      sel_d      = win;
      ack_d[win] = 1'b1;
      xen_d      = 1'b1;
      cnt_d      = CNT_W'(PKT_FLITS - 1);
    end

    // Grant and return in the same cycle cancel; a lone return saturates.
    if (grant && !crt_in)
      crt_d = crt_q - CRT_W'(1);
    else if (!grant && crt_in && crt_q != CRT_W'(BUF_PKTS))
      crt_d = crt_q + CRT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      xen_q   <= 1'b0;
      pen_q   <= 1'b0;
      crt_q   <= CRT_W'(BUF_PKTS);
`ifdef OPCU_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      xen_q   <= xen_d;
      pen_q   <= pen_d;
      crt_q   <= crt_d;
`ifdef OPCU_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign arb_ack  = ack_q;
  assign xbar_sel = sel_q;
  assign xbar_en  = xen_q;
  assign pipe_en  = pen_q;
  assign crt_cnt  = crt_q;

endmodule
